// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM state encoding,
// word geometry and the default text-segment base address.
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_COLLECT,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam int          BYTES_PER_WORD       = 4;
  localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h0040_0000;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Big-endian byte-to-word assembler: shifts bytes in at the low end and flags
// the transfer that completes a word.
module word_assembler
  import program_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  byte_fire,
  input  logic [7:0]            byte_data,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_ready
);

  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [1:0]            count_q, count_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    word_d  = word_q;
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (byte_fire) begin
      word_d  = {word_q[DATA_WIDTH-9:0], byte_data};
      count_d = count_q + 2'd1;
    end
  end

  assign word_ready = byte_fire && !clear && (count_q == 2'(BYTES_PER_WORD - 1));
  assign word       = word_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q  <= '0;
      count_q <= '0;
    end else begin
      word_q  <= word_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: header byte N, then N big-endian words written to program memory;
// holds the CPU until done. Define PROGRAM_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = DATA_WIDTH'(DEFAULT_BASE_ADDRESS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_write_enable,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam int IW = $clog2(MEMORY_DEPTH + 1);

  state_e                state_q, state_d;
  logic [IW-1:0]         index_q, index_d;
  logic [IW-1:0]         n_q, n_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic                  fire, asm_clear, asm_fire, word_ready;
  logic [DATA_WIDTH-1:0] asm_word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]            xor_q, xor_d;
`endif

  word_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_fire  (asm_fire),
    .byte_data  (byte_data),
    .word       (asm_word),
    .word_ready (word_ready)
  );

  assign byte_ready = (state_q == ST_HEADER) || (state_q == ST_COLLECT)
                   || (state_q == ST_CHECK);
  assign fire       = byte_valid && byte_ready;
  assign asm_fire   = fire && (state_q == ST_COLLECT);

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    n_d       = n_q;
    addr_d    = addr_q;
    asm_clear = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    xor_d     = xor_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) state_d = ST_HEADER;
      end
      ST_HEADER: begin
        if (fire) begin
          if (byte_data == 8'd0 || int'(byte_data) > MEMORY_DEPTH) begin
            state_d = ST_ERROR;
          end else begin
            n_d       = IW'(byte_data);
            index_d   = '0;
            asm_clear = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xor_d     = 8'd0;
`endif
            state_d   = ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (fire) xor_d = xor_q ^ byte_data;
`endif
        // Address is latched on entry to WRITE so it stays put until the next word.
        if (word_ready) begin
          addr_d  = BASE_ADDRESS + (DATA_WIDTH'(index_q) << 2);
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        index_d = index_q + IW'(1);
        if (index_d == n_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_COLLECT;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (fire) state_d = (byte_data == xor_q) ? ST_DONE : ST_ERROR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      n_q     <= '0;
      addr_q  <= BASE_ADDRESS;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  assign mem_write_enable = (state_q == ST_WRITE);
  assign mem_address      = addr_q;
  assign mem_write_data   = asm_word;
  assign cpu_hold         = (state_q != ST_DONE);
  assign done             = (state_q == ST_DONE);
  assign error            = (state_q == ST_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a stream-level model queues expected
// writes, a negedge monitor pops and compares every write strobe.
`timescale 1ns/1ps
module tb_program_loader;

  localparam int          DEPTH = 32;
  localparam logic [31:0] BASE  = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, mem_write_enable, cpu_hold, done, error;
  logic [31:0] mem_address, mem_write_data;

  program_loader #(.MEMORY_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .byte_valid       (byte_valid),
    .byte_data        (byte_data),
    .byte_ready       (byte_ready),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .cpu_hold         (cpu_hold),
    .done             (done),
    .error            (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t          exp_q[$];
  wr_t          mon_e;
  byte unsigned stream[$];
  int           vectors = 0;
  int           miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (mem_write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_address, mem_write_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", mem_address, mon_e.addr);
        check("write_data", mem_write_data, mon_e.data);
      end
    end
  end

  // Reference: writes for every complete word within the first `sent` bytes;
  // outcome 0 = still loading, 1 = done, 2 = error.
  function automatic int model_load(input int sent);
    int n, words;
    byte unsigned ck;
    if (sent < 1) return 0;
    n = int'(stream[0]);
    if (n == 0 || n > DEPTH) return 2;
    words = 0;
    for (int i = 0; i < n; i++) begin
      if (4 * i + 4 < sent) begin
        exp_q.push_back('{addr: BASE + 32'(4 * i),
                          data: {stream[1+4*i], stream[2+4*i], stream[3+4*i], stream[4+4*i]}});
        words++;
      end
    end
    if (words < n) return 0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (sent <= 1 + 4 * n) return 0;
    ck = 8'h00;
    for (int i = 1; i <= 4 * n; i++) ck = ck ^ stream[i];
    return (ck == stream[1 + 4 * n]) ? 1 : 2;
`else
    ck = 8'h00;
    return 1 + int'(ck);
`endif
  endfunction

  // Appends the XOR checksum byte in builds that expect one.
  task automatic finish_stream();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    byte unsigned ck = 8'h00;
    for (int i = 1; i < stream.size(); i++) ck = ck ^ stream[i];
    stream.push_back(ck);
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called just after a negedge; returns just after the negedge following the transfer.
  task automatic send_byte(input byte unsigned b);
    int waited = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!byte_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL byte_ready_timeout: got byte_ready 0 expected 1 within 50 cycles");
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic run_load(input int sent, input int max_gap, input bit mid_start, input bit reset_after);
    int outcome, cyc, n;
    outcome = model_load(sent);
    n = int'(stream[0]);
    pulse_start();
    for (int i = 0; i < sent; i++) begin
      send_byte(stream[i]);
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      if (mid_start && i == 2) pulse_start();
    end
    if (reset_after) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("reset_byte_ready", byte_ready, 1'b0);
      check("reset_cpu_hold", cpu_hold, 1'b1);
      check("reset_done", done, 1'b0);
      check("reset_mem_address", mem_address, BASE);
    end else begin
      cyc = 0;
      while (!(done || error) && cyc < 400) begin
        @(negedge clk);
        cyc++;
      end
      check("outcome_done", done, 32'(outcome == 1));
      check("outcome_error", error, 32'(outcome == 2));
      check("outcome_cpu_hold", cpu_hold, 32'(outcome != 1));
      if (outcome == 1) check("final_address", mem_address, BASE + 32'(4 * (n - 1)));
    end
    check("writes_drained", exp_q.size(), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_cpu_hold", cpu_hold, 1'b1);
      check("idle_flags", {done, error, byte_ready}, 3'b000);
    end
    check("idle_mem_address", mem_address, BASE);
    check("idle_mem_write_data", mem_write_data, 32'h0);

    // Two-word directed load, back-to-back bytes.
    stream = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    finish_stream();
    run_load(stream.size(), 0, 1'b0, 1'b0);

    // Illegal headers, then recovery.
    stream = '{8'h00};
    run_load(1, 0, 1'b0, 1'b0);
    stream = '{8'h21};
    run_load(1, 0, 1'b0, 1'b0);
    stream = '{8'(DEPTH + 1 + $urandom_range(0, 254 - DEPTH))};
    run_load(1, 0, 1'b0, 1'b0);
    stream = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    finish_stream();
    run_load(stream.size(), 0, 1'b0, 1'b0);

    // Same two-word load with a 3-cycle stall after the 2nd data byte.
    stream = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    finish_stream();
    begin
      void'(model_load(stream.size()));
      pulse_start();
      for (int i = 0; i < stream.size(); i++) begin
        send_byte(stream[i]);
        if (i == 2) repeat (3) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      check("stall_done", done, 1'b1);
      check("stall_drained", exp_q.size(), 0);
    end

    // Reset after header + 5 data bytes, then a one-word load.
    stream = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load(6, 0, 1'b0, 1'b1);
    stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h0C};
    finish_stream();
    run_load(stream.size(), 0, 1'b0, 1'b0);

    // Randomized loads with random gaps; one has a start pulse mid-load.
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 8);
      stream.delete();
      stream.push_back(8'(n));
      for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom_range(0, 255)));
      finish_stream();
      run_load(stream.size(), $urandom_range(0, 3), k == 1, 1'b0);
    end

    // Full-depth load exercises the highest address.
    stream.delete();
    stream.push_back(8'(DEPTH));
    for (int i = 0; i < 4 * DEPTH; i++) stream.push_back(8'($urandom_range(0, 255)));
    finish_stream();
    run_load(stream.size(), 0, 1'b0, 1'b0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    stream = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    run_load(stream.size(), 0, 1'b0, 1'b0);
    stream = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    run_load(stream.size(), 0, 1'b0, 1'b0);
`endif

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
